// File: rtl/sift_pkg.sv
// Shared types and sizing helpers for the SIFT descriptor pipeline.
package sift_pkg;

  localparam int unsigned PATCH_SIZE_DEFAULT = 4;

  // One histogram entry per sub-patch: 8 bins, each wide enough for a full sub-patch count.
  function automatic int unsigned entry_width(input int unsigned patch);
    return ($clog2((patch / 2) * (patch / 2)) + 1) * 8;
  endfunction

  localparam int unsigned ENTRY_W = entry_width(PATCH_SIZE_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } packer_state_t;

endpackage

// File: rtl/descriptor_packer.sv
// Reads groups of 4 sub-patch histogram entries from the descriptor BRAM and
// streams each group as one packed descriptor word over valid/ready.
module descriptor_packer
  import sift_pkg::*;
#(
  parameter int unsigned NUMBER_DESCRIPTORS = 4000,
  parameter int unsigned NUMBER_KEYPOINTS   = 1000,
  parameter int unsigned PATCH_SIZE         = PATCH_SIZE_DEFAULT,
  parameter int unsigned BRAM_LATENCY       = 2,
  localparam int unsigned DESC_ADDR_W = $clog2(NUMBER_DESCRIPTORS),
  localparam int unsigned KEY_IDX_W   = $clog2(NUMBER_KEYPOINTS),
  localparam int unsigned LANE_W      = entry_width(PATCH_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic [DESC_ADDR_W:0]     desc_count,
  output logic [DESC_ADDR_W-1:0]   desc_read_addr,
  input  logic [LANE_W-1:0]        desc_read,
  output logic [4*LANE_W-1:0]      packed_data,
  output logic [KEY_IDX_W-1:0]     packed_index,
  output logic                     packed_valid,
  input  logic                     packed_ready,
  output logic                     partial_flag,
  output logic                     busy,
  output logic                     packer_done
);

  localparam int unsigned WAIT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY + 1) : 1;

  packer_state_t state, state_next;

  logic [DESC_ADDR_W-1:0]       n_desc;
  logic [DESC_ADDR_W-1:0]       n_load;
  logic                         partial_load;
  logic                         over_range;
  logic [1:0]                   slot;
  logic [WAIT_W-1:0]            wait_cnt;
  logic [3:0][LANE_W-1:0]       asm_q;
  logic                         wait_done;
  logic                         last_word;
  logic                         handshake;
  logic [DESC_ADDR_W-1:0]       entry_addr;

  // Counts beyond the BRAM depth are clamped to the whole BRAM and flagged as partial.
  always_comb begin
    over_range   = desc_count > (DESC_ADDR_W+1)'(NUMBER_DESCRIPTORS);
    n_load       = over_range ? DESC_ADDR_W'(NUMBER_DESCRIPTORS >> 2)
                              : DESC_ADDR_W'(desc_count >> 2);
    partial_load = over_range | (|desc_count[1:0]);
  end

  assign wait_done  = wait_cnt == WAIT_W'(BRAM_LATENCY - 1);
  assign last_word  = (DESC_ADDR_W'(packed_index) + DESC_ADDR_W'(1)) == n_desc;
  assign handshake  = packed_valid & packed_ready;
  assign entry_addr = DESC_ADDR_W'({packed_index, 2'b00}) + DESC_ADDR_W'(slot);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (start) state_next = (n_load == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (wait_done) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = (slot == 2'd3) ? ST_EMIT : ST_ISSUE;
      ST_EMIT:    if (handshake) state_next = last_word ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = state != ST_IDLE;
    packer_done = state == ST_DONE;
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      n_desc         <= '0;
      partial_flag   <= 1'b0;
      slot           <= '0;
      wait_cnt       <= '0;
      packed_index   <= '0;
      desc_read_addr <= '0;
      asm_q          <= '0;
      packed_data    <= '0;
      packed_valid   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            n_desc         <= n_load;
            partial_flag   <= partial_load;
            slot           <= '0;
            desc_read_addr <= '0;
            packed_index   <= '0;
          end
        end
        ST_ISSUE: begin
          desc_read_addr <= entry_addr;
          wait_cnt       <= '0;
        end
        ST_WAIT: wait_cnt <= wait_cnt + WAIT_W'(1);
        ST_CAPTURE: begin
          asm_q[slot] <= desc_read;
          // Lane 3 is written into packed_data directly so the word is complete this edge.
          if (slot == 2'd3) begin
            packed_data  <= {desc_read, asm_q[2], asm_q[1], asm_q[0]};
            packed_valid <= 1'b1;
          end else begin
            slot <= slot + 2'd1;
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            packed_valid <= 1'b0;
            slot         <= '0;
            packed_index <= packed_index + KEY_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_descriptor_packer.sv
// Directed bench for descriptor_packer with a 2-cycle BRAM model.
module tb_descriptor_packer;

  localparam int unsigned EW = 24;
  localparam int unsigned AW = 12;
  localparam int unsigned IW = 10;
  localparam int SPACING = 17;

  logic            clk = 1'b0;
  logic            rst_in;
  logic            start;
  logic [AW:0]     desc_count;
  logic [AW-1:0]   desc_read_addr;
  logic [EW-1:0]   desc_read;
  logic [4*EW-1:0] packed_data;
  logic [IW-1:0]   packed_index;
  logic            packed_valid;
  logic            packed_ready;
  logic            partial_flag;
  logic            busy;
  logic            packer_done;

  int checks = 0;
  int errors = 0;

  descriptor_packer #(
    .NUMBER_DESCRIPTORS(4000),
    .NUMBER_KEYPOINTS(1000),
    .PATCH_SIZE(4),
    .BRAM_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .start(start),
    .desc_count(desc_count),
    .desc_read_addr(desc_read_addr),
    .desc_read(desc_read),
    .packed_data(packed_data),
    .packed_index(packed_index),
    .packed_valid(packed_valid),
    .packed_ready(packed_ready),
    .partial_flag(partial_flag),
    .busy(busy),
    .packer_done(packer_done)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] entry_val(input int a);
    return EW'((a + 1) * 32'h010101);
  endfunction

  function automatic logic [4*EW-1:0] exp_word(input int k);
    logic [4*EW-1:0] w;
    for (int j = 0; j < 4; j++) w[j*EW +: EW] = entry_val(4*k + j);
    return w;
  endfunction

  // BRAM model: data for an address appears two edges after the address is presented.
  logic [EW-1:0] bram_r1;
  always @(posedge clk) begin
    bram_r1   <= entry_val(int'(desc_read_addr));
    desc_read <= bram_r1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW:0] count;
    int          words;
    logic        partial;
    logic        mid_start;
  } vec_t;

  vec_t vecs[7];

  task automatic run_pass(input logic [AW:0] cnt, input int words, input logic partial,
                          input logic mid);
    int cyc;
    int got;
    int done_cnt;
    int done_cyc;
    int prev_v;
    int budget;
    got = 0; done_cnt = 0; done_cyc = -1; prev_v = 0;
    budget = words * SPACING + 10;
    @(negedge clk);
    desc_count = cnt; start = 1'b1; packed_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc <= budget) begin
      if (mid && cyc == 5) begin start = 1'b1; desc_count = 13'd4; end
      else if (mid && cyc == 6) start = 1'b0;
      if (packed_valid) begin
        if (got < words) begin
          chk($sformatf("word%0d_data", got), packed_data, exp_word(got));
          chk($sformatf("word%0d_index", got), packed_index, got);
        end
        if (got == 0) chk("first_latency", cyc, SPACING);
        else          chk("spacing", cyc - prev_v, SPACING);
        prev_v = cyc;
        got++;
      end
      if (packer_done) begin done_cnt++; done_cyc = cyc; end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("word_count_%0d", cnt), got, words);
    chk($sformatf("done_pulses_%0d", cnt), done_cnt, 1);
    chk($sformatf("done_cycle_%0d", cnt), done_cyc, (words == 0) ? 1 : prev_v + 1);
    chk($sformatf("partial_%0d", cnt), partial_flag, partial);
    chk($sformatf("idle_after_%0d", cnt), busy, 0);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n;
    n = 0;
    while (!packed_valid && n < bound) begin @(negedge clk); n++; end
    chk(name, packed_valid, 1);
  endtask

  initial begin
    logic [4*EW-1:0] held_data;
    int n;

    vecs[0] = '{13'd8,    2,    1'b0, 1'b0};
    vecs[1] = '{13'd6,    1,    1'b1, 1'b0};
    vecs[2] = '{13'd3,    0,    1'b1, 1'b0};
    vecs[3] = '{13'd16,   4,    1'b0, 1'b0};
    vecs[4] = '{13'd8,    2,    1'b0, 1'b1};
    vecs[5] = '{13'd0,    0,    1'b0, 1'b0};
    vecs[6] = '{13'd5000, 1000, 1'b1, 1'b0};

    rst_in = 1'b1; start = 1'b0; desc_count = '0; packed_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", desc_read_addr, 0);
    chk("rst_data", packed_data, 0);
    chk("rst_index", packed_index, 0);
    chk("rst_valid", packed_valid, 0);
    chk("rst_partial", partial_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", packer_done, 0);
    rst_in = 1'b0;

    for (int i = 0; i < 7; i++)
      run_pass(vecs[i].count, vecs[i].words, vecs[i].partial, vecs[i].mid_start);

    // Backpressure: ready held low for 20 cycles once the first word is valid.
    @(negedge clk);
    desc_count = 13'd8; start = 1'b1; packed_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp_first_valid", 40);
    packed_ready = 1'b0;
    held_data = packed_data;
    chk("bp_word0", held_data, exp_word(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid_held", packed_valid, 1);
      chk("bp_data_held", packed_data, held_data);
      chk("bp_index_held", packed_index, 0);
      chk("bp_addr_frozen", desc_read_addr, 3);
    end
    packed_ready = 1'b1;
    @(negedge clk);
    wait_valid("bp_second_valid", 40);
    chk("bp_word1", packed_data, exp_word(1));
    chk("bp_index1", packed_index, 1);
    n = 0;
    while (!packer_done && n < 10) begin @(negedge clk); n++; end
    chk("bp_done", packer_done, 1);
    @(negedge clk);
    chk("bp_idle", busy, 0);

    // Asynchronous reset during the BRAM wait of descriptor 1.
    @(negedge clk);
    desc_count = 13'd8; start = 1'b1; packed_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_index", packed_index, 1);
    chk("pre_rst_busy", busy, 1);
    rst_in = 1'b1;
    #1;
    chk("async_addr", desc_read_addr, 0);
    chk("async_data", packed_data, 0);
    chk("async_index", packed_index, 0);
    chk("async_valid", packed_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", packer_done, 0);
    @(negedge clk);
    rst_in = 1'b0;
    run_pass(13'd8, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
